niu_tx_arbiter: RTL and testbench
=================================

Name: niu_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares the single 10GBASE-R MAC transmit AXI-Stream port of the NIU between NUM_PORTS requesters (e.g. consensus, sync, and management engines). It sits in the clk156 domain between the requesters and the NIU tx_axis interface. Grants are locked per packet, so frames are never interleaved. Oversize frames are cut off at MAX_BEATS and marked bad via tuser. New grants are held off while the link is not ready.

Parameters:
NUM_PORTS, 4, number of requester AXIS slave ports (2..8)
DATA_W, 64, AXIS data width; keep width is DATA_W/8
MAX_BEATS, 1200, maximum beats per frame before forced truncation (≥2)

Ports:
clk156  in  1  156.25 MHz MAC clock; all logic on rising edge
aresetn  in  1  synchronous active-low reset
link_ready  in  1  NIU network_reset_done; gates new grants only
s_axis_tdata  in  NUM_PORTS*DATA_W  requester data, port i at [i*DATA_W +: DATA_W]
s_axis_tkeep  in  NUM_PORTS*DATA_W/8  requester byte enables
s_axis_tvalid  in  NUM_PORTS  per-port valid
s_axis_tlast  in  NUM_PORTS  per-port end of frame
s_axis_tready  out  NUM_PORTS  per-port ready
m_axis_tdata  out  DATA_W  to NIU tx_axis_tdata
m_axis_tkeep  out  DATA_W/8  to NIU tx_axis_tkeep
m_axis_tvalid  out  1  to NIU tx_axis_tvalid
m_axis_tlast  out  1  to NIU tx_axis_tlast
m_axis_tuser  out  1  1 = frame bad (truncated); MAC aborts it
m_axis_tready  in  1  from NIU tx_axis_tready
grant_idx  out  $clog2(NUM_PORTS)  currently or last granted port
busy  out  1  high in XFER or DRAIN
oversize_cnt  out  16  saturating count of truncated frames

Behaviour:
- States: IDLE, XFER, DRAIN. Reset (aresetn low at clock edge): state IDLE, last_grant=NUM_PORTS-1 so port 0 wins first, grant_idx=0, beat_cnt=0, oversize_cnt=0, busy=0; all s_axis_tready=0; m_axis_tvalid/tlast/tuser=0.
- IDLE: if link_ready=1 and any s_axis_tvalid=1, pick the first valid port searching upward from last_grant+1 (mod NUM_PORTS). Register it in grant_idx, go to XFER, clear beat_cnt. One arbitration cycle, no data moves in IDLE; s_axis_tready=0 in IDLE.
- XFER: combinational pass-through from granted port g: m_axis_tdata/tkeep/tvalid/tlast = port g signals; s_axis_tready[g]=m_axis_tready; other ports' tready=0; tuser=0. A beat is a cycle with m_axis_tvalid and m_axis_tready both high. beat_cnt increments per beat, width $clog2(MAX_BEATS+1).
- Beat with tlast=1 (beat_cnt < MAX_BEATS): last_grant<=g, go to IDLE. Minimum gap between frames is 1 cycle.
- Beat number MAX_BEATS without source tlast: force m_axis_tlast=1 and m_axis_tuser=1 on that beat. oversize_cnt increments, saturating at 16'hFFFF. last_grant<=g, go to DRAIN.
- Source tlast exactly on beat MAX_BEATS: normal completion, no tuser, no count.
- DRAIN: m_axis_tvalid=0; s_axis_tready[g]=1. Port g beats are discarded. On a discarded beat with tlast=1, go to IDLE.
- link_ready falling during XFER/DRAIN does not abort; the frame completes. Only IDLE grants are blocked.
- Source tvalid deasserting mid-frame (bubble): hold the grant, m_axis_tvalid follows.
- AXIS rule: m_axis outputs stay stable while tvalid=1 and tready=0, provided the source obeys AXIS.
- busy=1 when state≠IDLE. grant_idx holds its value in IDLE.

Test Plan:
- Ports 0 and 2 each post a 3-beat frame at the same time, m_tready=1 → port 0 frame (3 beats), 1 idle cycle, port 2 frame; last_grant=2.
- All 4 ports continuously valid with 1-beat frames → grant order 0,1,2,3,0,… with a beat every 2nd cycle.
- MAX_BEATS=4, port 1 sends a 6-beat frame → beat 4 carries tlast=1 and tuser=1, beats 5–6 are accepted and dropped (m_tvalid=0), oversize_cnt=1, then IDLE.
- link_ready=0 with port 0 valid → no tready and no output; link_ready→1 → XFER after 1 cycle. Dropping link_ready mid-frame → frame completes.
- m_tready toggles 1,0,1,0 during a 4-beat frame → output data stable while stalled; exactly 4 beats delivered in order, tkeep passed through (last beat 8'h0F).
- aresetn low for 1 cycle mid-frame → next cycle all outputs 0, state IDLE; the next arbitration grants port 0.

Source files
------------

// File: rtl/niu_tx_arbiter.sv
// -----------------------------------------------------------------------------
// niu_tx_arbiter
//   Packet-level round-robin arbiter sharing the NIU 10GBASE-R MAC transmit
//   AXI-Stream port between NUM_PORTS requesters, clk156 domain. A grant is
//   held for a whole frame so frames never interleave. Frames longer than
//   MAX_BEATS are cut on beat MAX_BEATS (tlast+tuser forced) and the rest of
//   the source frame is drained and discarded. New grants wait for link_ready.
//
// Ports:
//   clk156, aresetn        clock, synchronous active-low reset
//   link_ready             NIU reset done; gates new grants only
//   s_axis_*               NUM_PORTS requester slave streams (port i at slice i)
//   m_axis_*               master stream to NIU tx_axis; tuser=1 marks bad frame
//   grant_idx              currently or most recently granted port
//   busy                   high while a frame is being passed or drained
//   oversize_cnt           saturating count of truncated frames
// -----------------------------------------------------------------------------
module niu_tx_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 1200
) (
    input  logic                          clk156,
    input  logic                          aresetn,
    input  logic                          link_ready,
    input  logic [NUM_PORTS*DATA_W-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]          s_axis_tlast,
    output logic [NUM_PORTS-1:0]          s_axis_tready,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic [DATA_W/8-1:0]           m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    input  logic                          m_axis_tready,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_idx,
    output logic                          busy,
    output logic [15:0]                   oversize_cnt
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(NUM_PORTS);
    localparam int CNT_W  = $clog2(MAX_BEATS + 1);
    localparam logic [IDX_W-1:0] LAST_PORT  = IDX_W'(NUM_PORTS - 1);
    localparam logic [CNT_W-1:0] FINAL_BEAT = CNT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DRAIN
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_grant, w_grant_nxt;
    logic [IDX_W-1:0] r_last_grant, w_last_grant_nxt;
    logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
    logic [15:0]      r_oversize_cnt, w_oversize_cnt_nxt;

    logic [DATA_W-1:0] w_port_data [NUM_PORTS];
    logic [KEEP_W-1:0] w_port_keep [NUM_PORTS];

    logic             w_req_any;
    logic [IDX_W-1:0] w_req_pick;
    logic             w_src_valid;
    logic             w_src_last;
    logic             w_trunc;

    // Port that sits 'offset' places above 'base', wrapping at NUM_PORTS.
    function automatic logic [IDX_W-1:0] port_after(input logic [IDX_W-1:0] base,
                                                    input int unsigned      offset);
        int unsigned sum;
        sum = 32'(base) + offset;
        return IDX_W'(sum % 32'(NUM_PORTS));
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < 32'(NUM_PORTS); i++) begin
            w_port_data[i] = s_axis_tdata[i*DATA_W +: DATA_W];
            w_port_keep[i] = s_axis_tkeep[i*KEEP_W +: KEEP_W];
        end
    end

    // First requester searching upward from the port after the last grant.
    always_comb begin
        w_req_any  = 1'b0;
        w_req_pick = r_last_grant;
        for (int unsigned i = 1; i <= 32'(NUM_PORTS); i++) begin
            if (!w_req_any && s_axis_tvalid[port_after(r_last_grant, i)]) begin
                w_req_any  = 1'b1;
                w_req_pick = port_after(r_last_grant, i);
            end
        end
    end

    always_comb begin
        w_src_valid = s_axis_tvalid[r_grant];
        w_src_last  = s_axis_tlast[r_grant];
        // Beat number MAX_BEATS is presented while the count of completed
        // beats equals MAX_BEATS-1; a source tlast there is a clean finish.
        w_trunc     = (r_beat_cnt == FINAL_BEAT) && !w_src_last;

        w_state_nxt        = r_state;
        w_grant_nxt        = r_grant;
        w_last_grant_nxt   = r_last_grant;
        w_beat_cnt_nxt     = r_beat_cnt;
        w_oversize_cnt_nxt = r_oversize_cnt;

        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (link_ready && w_req_any) begin
                    w_state_nxt    = ST_XFER;
                    w_grant_nxt    = w_req_pick;
                    w_beat_cnt_nxt = '0;
                end
            end
            ST_XFER: begin
                m_axis_tdata           = w_port_data[r_grant];
                m_axis_tkeep           = w_port_keep[r_grant];
                m_axis_tvalid          = w_src_valid;
                m_axis_tlast           = w_src_last | w_trunc;
                m_axis_tuser           = w_trunc;
                s_axis_tready[r_grant] = m_axis_tready;
                if (w_src_valid && m_axis_tready) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    if (w_src_last) begin
                        w_state_nxt      = ST_IDLE;
                        w_last_grant_nxt = r_grant;
                    end else if (w_trunc) begin
                        w_state_nxt      = ST_DRAIN;
                        w_last_grant_nxt = r_grant;
                        if (r_oversize_cnt != 16'hFFFF) begin
                            w_oversize_cnt_nxt = r_oversize_cnt + 16'd1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // Swallow the remainder of the cut frame up to its own tlast.
                s_axis_tready[r_grant] = 1'b1;
                if (w_src_valid && w_src_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk156) begin
        if (!aresetn) begin
            r_state        <= ST_IDLE;
            r_grant        <= '0;
            r_last_grant   <= LAST_PORT;
            r_beat_cnt     <= '0;
            r_oversize_cnt <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_grant        <= w_grant_nxt;
            r_last_grant   <= w_last_grant_nxt;
            r_beat_cnt     <= w_beat_cnt_nxt;
            r_oversize_cnt <= w_oversize_cnt_nxt;
        end
    end

    assign grant_idx    = r_grant;
    assign busy         = (r_state != ST_IDLE);
    assign oversize_cnt = r_oversize_cnt;

endmodule

// File: tb/tb_niu_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_niu_tx_arbiter
//   Self-checking bench for niu_tx_arbiter (4 ports, 64-bit, MAX_BEATS=4).
//   Sources replay per-port frame memories under AXIS rules; output beats are
//   captured and compared against directed expectations and against a
//   frame-level round-robin/truncation model of the arbiter.
// -----------------------------------------------------------------------------
module tb_niu_tx_arbiter;

    localparam int NP  = 4;
    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int MB  = 4;
    localparam int MEM = 64;

    logic             clk156 = 1'b0;
    logic             aresetn;
    logic             link_ready;
    logic [NP*DW-1:0] s_axis_tdata;
    logic [NP*KW-1:0] s_axis_tkeep;
    logic [NP-1:0]    s_axis_tvalid;
    logic [NP-1:0]    s_axis_tlast;
    logic [NP-1:0]    s_axis_tready;
    logic [DW-1:0]    m_axis_tdata;
    logic [KW-1:0]    m_axis_tkeep;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tuser;
    logic             m_axis_tready;
    logic [1:0]       grant_idx;
    logic             busy;
    logic [15:0]      oversize_cnt;

    always #5 clk156 = ~clk156;

    niu_tx_arbiter #(
        .NUM_PORTS(NP),
        .DATA_W   (DW),
        .MAX_BEATS(MB)
    ) dut (
        .clk156       (clk156),
        .aresetn      (aresetn),
        .link_ready   (link_ready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .grant_idx    (grant_idx),
        .busy         (busy),
        .oversize_cnt (oversize_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        int          port;
        int          cyc;
    } beat_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0] src_data [NP][MEM];
    logic [7:0]  src_keep [NP][MEM];
    logic        src_last [NP][MEM];
    int          src_len  [NP];
    int          src_pos  [NP];
    logic        src_v    [NP];
    logic        hs       [NP];

    int ready_mode = 0;
    int ready_pct  = 100;
    int bubble_pct = 0;
    bit link_rand  = 0;

    beat_t cap_q[$];
    beat_t exp_q[$];

    logic        prev_stall = 1'b0;
    logic [63:0] sv_data;
    logic [7:0]  sv_keep;
    logic        sv_last, sv_user;
    int          stall_cnt = 0;

    logic        smp_mvalid, smp_mlast, smp_muser, smp_busy;
    logic [1:0]  smp_grant;
    logic [3:0]  smp_sready;
    logic [15:0] smp_ovs;

    task automatic clear_sources();
        for (int p = 0; p < NP; p++) begin
            src_len[p] = 0;
            src_pos[p] = 0;
            src_v[p]   = 1'b0;
            hs[p]      = 1'b0;
        end
    endtask

    task automatic load_frame(input int p, input int n, input logic [7:0] last_keep);
        for (int b = 0; b < n; b++) begin
            if (src_len[p] < MEM) begin
                src_data[p][src_len[p]] = {$urandom, $urandom};
                src_keep[p][src_len[p]] = (b == n - 1) ? last_keep : 8'hFF;
                src_last[p][src_len[p]] = (b == n - 1);
                src_len[p]++;
            end
        end
    endtask

    task automatic drive_inputs();
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        for (int p = 0; p < NP; p++) begin
            if (src_v[p]) begin
                s_axis_tvalid[p]         = 1'b1;
                s_axis_tdata[p*DW +: DW] = src_data[p][src_pos[p]];
                s_axis_tkeep[p*KW +: KW] = src_keep[p][src_pos[p]];
                s_axis_tlast[p]          = src_last[p][src_pos[p]];
            end
        end
    endtask

    task automatic arm();
        for (int p = 0; p < NP; p++) begin
            if (!src_v[p] && src_pos[p] < src_len[p]) src_v[p] = 1'b1;
        end
        drive_inputs();
    endtask

    task automatic sample();
        for (int p = 0; p < NP; p++) hs[p] = s_axis_tvalid[p] & s_axis_tready[p];
        if (prev_stall) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== sv_data || m_axis_tkeep !== sv_keep ||
                m_axis_tlast !== sv_last || m_axis_tuser !== sv_user) begin
                errors++;
                $display("FAIL stall_stable: got v=%b d=%h k=%h l=%b u=%b want v=1 d=%h k=%h l=%b u=%b",
                         m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                         sv_data, sv_keep, sv_last, sv_user);
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        if (prev_stall) begin
            stall_cnt++;
            sv_data = m_axis_tdata;
            sv_keep = m_axis_tkeep;
            sv_last = m_axis_tlast;
            sv_user = m_axis_tuser;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            beat_t c;
            c.data = m_axis_tdata;
            c.keep = m_axis_tkeep;
            c.last = m_axis_tlast;
            c.user = m_axis_tuser;
            c.port = int'(grant_idx);
            c.cyc  = cyc;
            cap_q.push_back(c);
        end
        smp_mvalid = m_axis_tvalid;
        smp_mlast  = m_axis_tlast;
        smp_muser  = m_axis_tuser;
        smp_busy   = busy;
        smp_grant  = grant_idx;
        smp_sready = s_axis_tready;
        smp_ovs    = oversize_cnt;
    endtask

    task automatic advance();
        cyc++;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                src_pos[p]++;
                if (src_pos[p] < src_len[p]) begin
                    // A new frame is offered at once; only mid-frame beats may bubble.
                    if (src_last[p][src_pos[p]-1]) src_v[p] = 1'b1;
                    else src_v[p] = ($urandom_range(99) >= bubble_pct);
                end else begin
                    src_v[p] = 1'b0;
                end
            end else if (!src_v[p] && src_pos[p] < src_len[p]) begin
                src_v[p] = ($urandom_range(99) >= bubble_pct);
            end
            hs[p] = 1'b0;
        end
        case (ready_mode)
            1:       m_axis_tready = ($urandom_range(99) < ready_pct);
            2:       m_axis_tready = ((cyc % 2) == 0);
            default: m_axis_tready = 1'b1;
        endcase
        if (link_rand) link_ready = ($urandom_range(99) < 80);
        drive_inputs();
    endtask

    task automatic tick();
        @(negedge clk156);
        sample();
        @(posedge clk156);
        #1;
        advance();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_sources();
        drive_inputs();
        tick();
        tick();
        aresetn    = 1'b1;
        prev_stall = 1'b0;
        cap_q.delete();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int  n;
        bit  done;
        done = 0;
        n    = 0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = !smp_busy;
            for (int p = 0; p < NP; p++) if (src_pos[p] < src_len[p]) done = 0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: arbiter still busy or sources pending after %0d cycles, want idle", name, budget);
        end
    endtask

    task automatic test_reset();
        aresetn    = 1'b0;
        link_ready = 1'b1;
        clear_sources();
        load_frame(0, 3, 8'hFF);
        arm();
        tick();
        tick();
        checks++;
        if ({smp_mvalid, smp_mlast, smp_muser, smp_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl: got tvalid/tlast/tuser/busy=%b want 0000",
                     {smp_mvalid, smp_mlast, smp_muser, smp_busy});
        end
        checks++;
        if (smp_grant !== 2'd0) begin
            errors++;
            $display("FAIL reset_grant: got %0d want 0", smp_grant);
        end
        checks++;
        if (smp_sready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_sready: got %b want 0000", smp_sready);
        end
        checks++;
        if (smp_ovs !== 16'd0) begin
            errors++;
            $display("FAIL reset_ovs: got %0d want 0", smp_ovs);
        end
        aresetn = 1'b1;
        clear_sources();
        drive_inputs();
        cap_q.delete();
    endtask

    task automatic test_two_ports();
        int start;
        int offs[6]  = '{1, 2, 3, 5, 6, 7};
        int ports[6] = '{0, 0, 0, 2, 2, 2};
        int bidx[6]  = '{0, 1, 2, 0, 1, 2};
        clear_sources();
        cap_q.delete();
        load_frame(0, 3, 8'hFF);
        load_frame(2, 3, 8'hFF);
        start = cyc;
        arm();
        wait_idle(50, "two_ports");
        checks++;
        if (cap_q.size() != 6) begin
            errors++;
            $display("FAIL two_ports_count: got %0d beats want 6", cap_q.size());
        end
        for (int k = 0; k < 6 && k < cap_q.size(); k++) begin
            checks++;
            if (cap_q[k].port != ports[k] || cap_q[k].cyc != start + offs[k] ||
                cap_q[k].data !== src_data[ports[k]][bidx[k]] || cap_q[k].last !== (bidx[k] == 2) ||
                cap_q[k].user !== 1'b0) begin
                errors++;
                $display("FAIL two_ports_beat%0d: got port=%0d cyc=+%0d d=%h l=%b u=%b want port=%0d cyc=+%0d d=%h l=%b u=0",
                         k, cap_q[k].port, cap_q[k].cyc - start, cap_q[k].data, cap_q[k].last, cap_q[k].user,
                         ports[k], offs[k], src_data[ports[k]][bidx[k]], (bidx[k] == 2));
            end
        end
        checks++;
        if (grant_idx !== 2'd2) begin
            errors++;
            $display("FAIL two_ports_grant: got %0d want 2", grant_idx);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int f = 0; f < 3; f++) for (int p = 0; p < NP; p++) load_frame(p, 1, 8'hFF);
        arm();
        wait_idle(200, "round_robin");
        checks++;
        if (cap_q.size() != 12) begin
            errors++;
            $display("FAIL rr_count: got %0d beats want 12", cap_q.size());
        end
        for (int k = 0; k < 12 && k < cap_q.size(); k++) begin
            checks++;
            if (cap_q[k].port != k % NP || cap_q[k].data !== src_data[k % NP][k / NP] ||
                (k > 0 && cap_q[k].cyc - cap_q[k-1].cyc != 2)) begin
                errors++;
                $display("FAIL rr_beat%0d: got port=%0d d=%h gap=%0d want port=%0d d=%h gap=2",
                         k, cap_q[k].port, cap_q[k].data, (k > 0) ? cap_q[k].cyc - cap_q[k-1].cyc : 2,
                         k % NP, src_data[k % NP][k / NP]);
            end
        end
    endtask

    task automatic test_oversize();
        int bi[12]  = '{0, 1, 2, 3, 6, 7, 8, 9, 10, 11, 12, 13};
        bit eu[12]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        bit el[12]  = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
        do_reset();
        load_frame(1, 6, 8'hFF);
        load_frame(1, 4, 8'h3F);
        load_frame(1, 5, 8'hFF);
        arm();
        wait_idle(200, "oversize");
        checks++;
        if (cap_q.size() != 12) begin
            errors++;
            $display("FAIL ovs_count: got %0d beats want 12", cap_q.size());
        end
        for (int k = 0; k < 12 && k < cap_q.size(); k++) begin
            checks++;
            if (cap_q[k].port != 1 || cap_q[k].data !== src_data[1][bi[k]] ||
                cap_q[k].keep !== src_keep[1][bi[k]] || cap_q[k].last !== el[k] || cap_q[k].user !== eu[k]) begin
                errors++;
                $display("FAIL ovs_beat%0d: got port=%0d d=%h k=%h l=%b u=%b want port=1 d=%h k=%h l=%b u=%b",
                         k, cap_q[k].port, cap_q[k].data, cap_q[k].keep, cap_q[k].last, cap_q[k].user,
                         src_data[1][bi[k]], src_keep[1][bi[k]], el[k], eu[k]);
            end
        end
        checks++;
        if (oversize_cnt !== 16'd2) begin
            errors++;
            $display("FAIL ovs_cnt: got %0d want 2", oversize_cnt);
        end
    endtask

    task automatic test_link_ready();
        int start;
        int n;
        do_reset();
        link_ready = 1'b0;
        load_frame(0, 3, 8'hFF);
        arm();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (smp_sready !== 4'b0000 || smp_mvalid !== 1'b0 || smp_busy !== 1'b0) begin
                errors++;
                $display("FAIL link_hold%0d: got sready=%b tvalid=%b busy=%b want 0000 0 0",
                         i, smp_sready, smp_mvalid, smp_busy);
            end
        end
        link_ready = 1'b1;
        start      = cyc;
        n          = 0;
        while (cap_q.size() == 0 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (cap_q.size() == 0) begin
            errors++;
            $display("FAIL link_first_beat: got no beat want beat at +1");
        end else if (cap_q[0].cyc != start + 1) begin
            errors++;
            $display("FAIL link_first_beat: got beat at +%0d want +1", cap_q[0].cyc - start);
        end
        link_ready = 1'b0;
        wait_idle(30, "link_drop");
        checks++;
        if (cap_q.size() != 3 || cap_q[cap_q.size()-1].last !== 1'b1) begin
            errors++;
            $display("FAIL link_drop_complete: got %0d beats want 3 ending with tlast", cap_q.size());
        end
        link_ready = 1'b1;
    endtask

    task automatic test_stall();
        int s0;
        do_reset();
        ready_mode = 2;
        s0         = stall_cnt;
        load_frame(3, 4, 8'h0F);
        arm();
        wait_idle(60, "stall");
        ready_mode = 0;
        checks++;
        if (stall_cnt - s0 < 2) begin
            errors++;
            $display("FAIL stall_seen: got %0d stalled cycles want at least 2", stall_cnt - s0);
        end
        checks++;
        if (cap_q.size() != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d beats want 4", cap_q.size());
        end
        for (int k = 0; k < 4 && k < cap_q.size(); k++) begin
            checks++;
            if (cap_q[k].data !== src_data[3][k] || cap_q[k].keep !== ((k == 3) ? 8'h0F : 8'hFF) ||
                cap_q[k].last !== (k == 3) || cap_q[k].port != 3) begin
                errors++;
                $display("FAIL stall_beat%0d: got d=%h k=%h l=%b port=%0d want d=%h k=%h l=%b port=3",
                         k, cap_q[k].data, cap_q[k].keep, cap_q[k].last, cap_q[k].port,
                         src_data[3][k], (k == 3) ? 8'h0F : 8'hFF, (k == 3));
            end
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        clear_sources();
        cap_q.delete();
        load_frame(0, 1, 8'hFF);
        load_frame(1, 4, 8'hFF);
        arm();
        n = 0;
        while (cap_q.size() < 3 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (cap_q.size() < 3) begin
            errors++;
            $display("FAIL midrst_setup: got %0d beats want 3 before reset", cap_q.size());
        end
        aresetn = 1'b0;
        tick();
        aresetn    = 1'b1;
        prev_stall = 1'b0;
        clear_sources();
        cap_q.delete();
        load_frame(2, 2, 8'hFF);
        load_frame(0, 2, 8'hFF);
        arm();
        tick();
        checks++;
        if ({smp_mvalid, smp_mlast, smp_muser, smp_busy, smp_grant, smp_sready} !== 10'd0 || smp_ovs !== 16'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got v/l/u/busy/grant/sready=%b ovs=%0d want all 0",
                     {smp_mvalid, smp_mlast, smp_muser, smp_busy, smp_grant, smp_sready}, smp_ovs);
        end
        wait_idle(50, "midrst");
        checks++;
        if (cap_q.size() != 4 || cap_q[0].port != 0 || cap_q[2].port != 2) begin
            errors++;
            $display("FAIL midrst_order: got %0d beats first port=%0d want 4 beats port 0 then 2",
                     cap_q.size(), (cap_q.size() > 0) ? cap_q[0].port : -1);
        end
    endtask

    task automatic test_random(input int round);
        int ptr[NP];
        int last_g, g, n, kept, ovs;
        do_reset();
        for (int p = 0; p < NP; p++) begin
            int nf;
            nf = $urandom_range(4, 1);
            for (int f = 0; f < nf; f++) load_frame(p, $urandom_range(7, 1), 8'hFF >> $urandom_range(7));
        end
        // Frame-level model: every port with frames left is requesting at each
        // arbitration point, so the grant order is pure round-robin over them.
        exp_q.delete();
        ovs    = 0;
        last_g = NP - 1;
        for (int p = 0; p < NP; p++) ptr[p] = 0;
        while (1) begin
            g = -1;
            for (int off = 1; off <= NP; off++) begin
                int c;
                c = (last_g + off) % NP;
                if (g < 0 && ptr[c] < src_len[c]) g = c;
            end
            if (g < 0) break;
            n = 1;
            while (!src_last[g][ptr[g] + n - 1]) n++;
            kept = (n > MB) ? MB : n;
            for (int b = 0; b < kept; b++) begin
                beat_t e;
                e.data = src_data[g][ptr[g] + b];
                e.keep = src_keep[g][ptr[g] + b];
                e.last = (b == kept - 1);
                e.user = (n > MB) && (b == kept - 1);
                e.port = g;
                e.cyc  = 0;
                exp_q.push_back(e);
            end
            if (n > MB) ovs++;
            ptr[g] += n;
            last_g = g;
        end
        ready_mode = 1;
        ready_pct  = 70;
        bubble_pct = 30;
        link_rand  = 1;
        arm();
        wait_idle(3000, "random");
        ready_mode = 0;
        bubble_pct = 0;
        link_rand  = 0;
        link_ready = 1'b1;
        drive_inputs();
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand%0d_count: got %0d beats want %0d", round, cap_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
            checks++;
            if (cap_q[k].port != exp_q[k].port || cap_q[k].data !== exp_q[k].data ||
                cap_q[k].keep !== exp_q[k].keep || cap_q[k].last !== exp_q[k].last ||
                cap_q[k].user !== exp_q[k].user) begin
                errors++;
                $display("FAIL rand%0d_beat%0d: got p=%0d d=%h k=%h l=%b u=%b want p=%0d d=%h k=%h l=%b u=%b",
                         round, k, cap_q[k].port, cap_q[k].data, cap_q[k].keep, cap_q[k].last, cap_q[k].user,
                         exp_q[k].port, exp_q[k].data, exp_q[k].keep, exp_q[k].last, exp_q[k].user);
            end
        end
        checks++;
        if (oversize_cnt !== 16'(ovs)) begin
            errors++;
            $display("FAIL rand%0d_ovs: got %0d want %0d", round, oversize_cnt, ovs);
        end
    endtask

    initial begin
        aresetn       = 1'b0;
        link_ready    = 1'b1;
        m_axis_tready = 1'b1;
        clear_sources();
        drive_inputs();
        test_reset();
        test_two_ports();
        test_round_robin();
        test_oversize();
        test_link_ready();
        test_stall();
        test_reset_midframe();
        for (int r = 0; r < 3; r++) test_random(r);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
